score_keeper: RTL and testbench

- Downstream consumer of the apple stage's score_increment pulse.
- Keeps a 4-digit BCD score and a session high score, and runs a small play-state machine (IDLE/PLAY/OVER).
- Time-multiplexes the selected value onto a 4-digit common-anode seven-segment display.
- Runs in the VGA_clk domain alongside the apple and snake logic.

---
 rtl/snake_pkg.sv | 22 ++
 rtl/bcd_to_7seg.sv | 13 +
 rtl/score_keeper.sv | 120 ++++++++++++
 tb/tb_score_keeper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game blocks: play-state encoding, BCD sizing
// and the active-low seven-segment glyph table.
package snake_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int DIGIT_W = 4;
  localparam int DIGITS  = 4;

  // {g,f,e,d,c,b,a}, active-low; non-decimal codes blank the digit
  localparam logic [6:0] SEG_GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
  };

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Single BCD digit to active-low seven-segment glyph lookup.
module bcd_to_7seg
  import snake_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_GLYPH[bcd];
  end

endmodule

// File: rtl/score_keeper.sv
// BCD score / high-score keeper with IDLE-PLAY-OVER play state and a
// time-multiplexed 4-digit common-anode seven-segment driver.
module score_keeper
  import snake_pkg::*;
#(
  parameter int REFRESH_BITS = 16,
  parameter int MAX_SCORE    = 9999
) (
  input  logic        VGA_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        game_over,
  input  logic        score_increment,
  input  logic        show_high,
  output logic [15:0] score,
  output logic [15:0] high_score,
  output logic        playing,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int          SCORE_W = DIGITS * DIGIT_W;
  localparam logic [15:0] MAX_BCD = to_bcd(MAX_SCORE);

  logic [1:0]              state;
  logic                    inc_d;
  logic                    go_d;
  logic                    inc_edge;
  logic                    go_edge;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              digit_idx;
  logic [SCORE_W-1:0]      sel_val;
  logic [DIGIT_W-1:0]      sel_digit;
  logic [6:0]              seg_next;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[i*DIGIT_W +: DIGIT_W] == 4'd9) begin
          r[i*DIGIT_W +: DIGIT_W] = 4'd0;
        end else begin
          r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Most significant differing digit decides
  function automatic logic bcd_gt(input logic [15:0] a, input logic [15:0] b);
    logic decided;
    logic gt;
    decided = 1'b0;
    gt      = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*DIGIT_W +: DIGIT_W] != b[i*DIGIT_W +: DIGIT_W])) begin
        decided = 1'b1;
        gt      = a[i*DIGIT_W +: DIGIT_W] > b[i*DIGIT_W +: DIGIT_W];
      end
    end
    return gt;
  endfunction

  assign inc_edge = score_increment & ~inc_d;
  assign go_edge  = game_over & ~go_d;

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      playing    <= 1'b0;
      score      <= '0;
      high_score <= '0;
      inc_d      <= 1'b0;
      go_d       <= 1'b0;
    end else begin
      inc_d <= score_increment;
      go_d  <= game_over;
      if (start) begin
        state   <= ST_PLAY;
        playing <= 1'b1;
        score   <= '0;
      end else if (state == ST_PLAY && go_edge) begin
        state   <= ST_OVER;
        playing <= 1'b0;
        if (bcd_gt(score, high_score)) high_score <= score;
      end else if (state == ST_PLAY && inc_edge && score != MAX_BCD) begin
        score <= bcd_inc(score);
      end
    end
  end

  // Display refresh: digit index steps whenever the counter wraps
  assign sel_val   = show_high ? high_score : score;
  assign sel_digit = sel_val[{digit_idx, 2'b00} +: DIGIT_W];

  bcd_to_7seg u_dec (
    .bcd (sel_digit),
    .seg (seg_next)
  );

  always_ff @(posedge VGA_clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      an          <= 4'b1110;
      seg         <= 7'b1000000;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
      if (&refresh_cnt) digit_idx <= digit_idx + 2'd1;
      an  <= ~(4'b0001 << digit_idx);
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Randomised and directed bench for score_keeper against a decimal reference model.
module tb_score_keeper;

  localparam int RB = 2;

  logic        VGA_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        game_over = 1'b0;
  logic        score_increment = 1'b0;
  logic        show_high = 1'b0;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        playing;
  logic [3:0]  an;
  logic [6:0]  seg;

  int total = 0;
  int bad = 0;

  // Reference model: plain decimal integers and an edge count since reset
  int       m_state;   // 0 idle, 1 play, 2 over
  int       m_score;
  int       m_high;
  int       m_k;
  bit       m_inc_d;
  bit       m_go_d;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  int       p10 [4] = '{1, 10, 100, 1000};

  score_keeper #(.REFRESH_BITS(RB), .MAX_SCORE(9999)) dut (
    .VGA_clk         (VGA_clk),
    .rst             (rst),
    .start           (start),
    .game_over       (game_over),
    .score_increment (score_increment),
    .show_high       (show_high),
    .score           (score),
    .high_score      (high_score),
    .playing         (playing),
    .an              (an),
    .seg             (seg)
  );

  always #5 VGA_clk = ~VGA_clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic m_reset();
    m_state = 0; m_score = 0; m_high = 0; m_k = 0;
    m_inc_d = 0; m_go_d = 0;
    e_an = 4'b1110; e_seg = 7'b1000000;
  endtask

  // One clock: update the model from the inputs seen at the edge, return on the falling edge
  task automatic cycle();
    int  idx;
    int  dval;
    bit  ie;
    bit  ge;
    @(posedge VGA_clk);
    idx   = (m_k >> RB) % 4;
    dval  = show_high ? m_high : m_score;
    e_an  = ~(4'b0001 << idx);
    e_seg = glyph((dval / p10[idx]) % 10);
    ie = score_increment && !m_inc_d;
    ge = game_over && !m_go_d;
    if (start) begin
      m_state = 1; m_score = 0;
    end else if (m_state == 1 && ge) begin
      m_state = 2;
      if (m_score > m_high) m_high = m_score;
    end else if (m_state == 1 && ie && m_score < 9999) begin
      m_score++;
    end
    m_inc_d = score_increment;
    m_go_d  = game_over;
    m_k++;
    @(negedge VGA_clk);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      score_increment = 1'b1; cycle();
      score_increment = 1'b0; cycle();
    end
  endtask

  task automatic do_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (score !== 16'h0000) begin bad++; $display("FAIL reset_score got=%h want=0000", score); end
    total++; if (high_score !== 16'h0000) begin bad++; $display("FAIL reset_high got=%h want=0000", high_score); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL reset_playing got=%b want=0", playing); end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL reset_an got=%b want=1110", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL reset_seg got=%b want=1000000", seg); end
    @(negedge VGA_clk);
    m_reset();
    rst = 1'b0;
    pulses(2);
    total++; if (score !== 16'h0000) begin bad++; $display("FAIL idle_ignore got=%h want=0000", score); end
  endtask

  task automatic test_start_increments();
    do_start();
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL start_playing got=%b want=1", playing); end
    for (int i = 1; i <= 3; i++) begin
      score_increment = 1'b1; cycle(); score_increment = 1'b0;
      total++; if (score !== 16'(i)) begin bad++; $display("FAIL inc_latency got=%h want=%h", score, 16'(i)); end
      repeat (3) cycle();
    end
  endtask

  task automatic test_held();
    score_increment = 1'b1;
    repeat (20) cycle();
    score_increment = 1'b0;
    cycle();
    total++; if (score !== 16'h0004) begin bad++; $display("FAIL held_level got=%h want=0004", score); end
  endtask

  task automatic test_high_score();
    pulses(38);
    total++; if (score !== 16'h0042) begin bad++; $display("FAIL reach_42 got=%h want=0042", score); end
    game_over = 1'b1; cycle();
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL over_playing got=%b want=0", playing); end
    total++; if (high_score !== 16'h0042) begin bad++; $display("FAIL high_42 got=%h want=0042", high_score); end
    game_over = 1'b0; cycle();
    pulses(2);
    total++; if (score !== 16'h0042) begin bad++; $display("FAIL over_ignore got=%h want=0042", score); end
    do_start();
    pulses(7);
    game_over = 1'b1; cycle(); game_over = 1'b0; cycle();
    total++; if (high_score !== 16'h0042) begin bad++; $display("FAIL high_kept got=%h want=0042", high_score); end
    total++; if (score !== 16'h0007) begin bad++; $display("FAIL score_7 got=%h want=0007", score); end
  endtask

  task automatic test_carry();
    do_start();
    pulses(99);
    total++; if (score !== 16'h0099) begin bad++; $display("FAIL reach_99 got=%h want=0099", score); end
    pulses(1);
    total++; if (score !== 16'h0100) begin bad++; $display("FAIL carry_100 got=%h want=0100", score); end
    pulses(9899);
    total++; if (score !== 16'h9999) begin bad++; $display("FAIL reach_9999 got=%h want=9999", score); end
    pulses(1);
    total++; if (score !== 16'h9999) begin bad++; $display("FAIL saturate got=%h want=9999", score); end
  endtask

  task automatic test_display();
    do_start();
    pulses(1234);
    total++; if (score !== 16'h1234) begin bad++; $display("FAIL reach_1234 got=%h want=1234", score); end
    for (int pass = 0; pass < 2; pass++) begin
      show_high = (pass == 1);
      for (int i = 0; i < 24; i++) begin
        cycle();
        total++; if (an !== e_an) begin bad++; $display("FAIL disp_an got=%b want=%b", an, e_an); end
        total++; if (seg !== e_seg) begin bad++; $display("FAIL disp_seg got=%b want=%b sh=%b", seg, e_seg, show_high); end
      end
    end
    show_high = 1'b0;
  endtask

  task automatic test_start_go_same();
    start = 1'b1; game_over = 1'b1; cycle();
    start = 1'b0; game_over = 1'b0;
    total++; if (score !== 16'h0000) begin bad++; $display("FAIL startgo_score got=%h want=0000", score); end
    total++; if (high_score !== 16'h0042) begin bad++; $display("FAIL startgo_high got=%h want=0042", high_score); end
    total++; if (playing !== 1'b1) begin bad++; $display("FAIL startgo_playing got=%b want=1", playing); end
    cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start           = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) game_over = ~game_over;
      score_increment = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) show_high = ~show_high;
      cycle();
      total++; if (score !== to_bcd(m_score)) begin bad++; $display("FAIL rnd_score got=%h want=%h", score, to_bcd(m_score)); end
      total++; if (high_score !== to_bcd(m_high)) begin bad++; $display("FAIL rnd_high got=%h want=%h", high_score, to_bcd(m_high)); end
      total++; if (playing !== (m_state == 1)) begin bad++; $display("FAIL rnd_playing got=%b want=%b", playing, m_state == 1); end
      total++; if (an !== e_an) begin bad++; $display("FAIL rnd_an got=%b want=%b", an, e_an); end
      total++; if (seg !== e_seg) begin bad++; $display("FAIL rnd_seg got=%b want=%b", seg, e_seg); end
    end
    start = 1'b0; game_over = 1'b0; score_increment = 1'b0; show_high = 1'b0;
    cycle();
  endtask

  task automatic test_async_reset();
    do_start();
    pulses(3);
    #2 rst = 1'b1;
    #1;
    total++; if (score !== 16'h0000) begin bad++; $display("FAIL arst_score got=%h want=0000", score); end
    total++; if (high_score !== 16'h0000) begin bad++; $display("FAIL arst_high got=%h want=0000", high_score); end
    total++; if (playing !== 1'b0) begin bad++; $display("FAIL arst_playing got=%b want=0", playing); end
    total++; if (an !== 4'b1110) begin bad++; $display("FAIL arst_an got=%b want=1110", an); end
    total++; if (seg !== 7'b1000000) begin bad++; $display("FAIL arst_seg got=%b want=1000000", seg); end
    @(negedge VGA_clk);
    m_reset();
    rst = 1'b0;
    cycle();
    total++; if (an !== e_an) begin bad++; $display("FAIL arst_resume_an got=%b want=%b", an, e_an); end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_start_increments();
    test_held();
    test_high_score();
    test_carry();
    test_display();
    test_start_go_same();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
